// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO port controller: register word offsets,
// the default GPIO vector type and the byte-enable expansion helper.
package gpio_pkg;

  localparam int unsigned GPIO_NB = 32;

  typedef logic [GPIO_NB-1:0] gpio_vec_t;

  localparam logic [31:0] GPIO_DIR   = 32'd0;
  localparam logic [31:0] GPIO_OUT   = 32'd1;
  localparam logic [31:0] GPIO_IN    = 32'd2;
  localparam logic [31:0] GPIO_STAT  = 32'd3;
  localparam logic [31:0] GPIO_MASK  = 32'd4;
  localparam logic [31:0] GPIO_POSE  = 32'd5;
  localparam logic [31:0] GPIO_NEGE  = 32'd6;
  localparam logic [31:0] GPIO_MFUNC = 32'd7;

  // Expands the four byte enables into a 32-bit write mask.
  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) begin
      m[i*8 +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Input conditioning for the raw pad data: a SYNC_STAGES-deep synchroniser
// chain followed by one history flop so that single-cycle rise/fall pulses can
// be derived from consecutive synchronised samples.
module gpio_sync_edge
  import gpio_pkg::*;
#(
  parameter int NB_GPIO     = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic               mclk,
  input  logic               h_reset,
  input  logic [NB_GPIO-1:0] pad_gpio_in,
  output logic [NB_GPIO-1:0] sync_in,
  output logic [NB_GPIO-1:0] rise,
  output logic [NB_GPIO-1:0] fall
);

  logic [SYNC_STAGES-1:0][NB_GPIO-1:0] sync_q;
  logic [NB_GPIO-1:0]                  prev_q;

  // Shift the pad sample through the synchroniser and remember the last output.
  always_ff @(posedge mclk or posedge h_reset) begin
    if (h_reset) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad_gpio_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_in = sync_q[SYNC_STAGES-1];
  assign rise    = sync_in & ~prev_q;
  assign fall    = ~sync_in & prev_q;

endmodule

// File: rtl/gpio_port_ctrl.sv
// Register-mapped GPIO controller: holds the direction/output/function
// registers feeding the pinmux, captures sticky edge status from the
// synchronised pad inputs and raises a masked level interrupt.
module gpio_port_ctrl
  import gpio_pkg::*;
#(
  parameter int NB_GPIO     = 32,
  parameter int SYNC_STAGES = 2,
  parameter int AW          = 3
) (
  input  logic               mclk,
  input  logic               h_reset,
  input  logic               reg_cs,
  input  logic               reg_wr,
  input  logic [AW-1:0]      reg_addr,
  input  logic [3:0]         reg_be,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata,
  output logic               reg_ack,
  output logic [NB_GPIO-1:0] cfg_gpio_dir_sel,
  output logic [31:0]        cfg_multi_func_sel,
  output logic [NB_GPIO-1:0] pad_gpio_out,
  input  logic [NB_GPIO-1:0] pad_gpio_in,
  output logic               gpio_intr
);

  logic [NB_GPIO-1:0] dir_q, dir_d;
  logic [NB_GPIO-1:0] out_q, out_d;
  logic [NB_GPIO-1:0] stat_q, stat_d;
  logic [NB_GPIO-1:0] mask_q, mask_d;
  logic [NB_GPIO-1:0] pose_q, pose_d;
  logic [NB_GPIO-1:0] nege_q, nege_d;
  logic [31:0]        mfunc_q, mfunc_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               busy_q;
  logic               ack_q;
  logic               intr_q;

  logic [NB_GPIO-1:0] sync_in;
  logic [NB_GPIO-1:0] rise;
  logic [NB_GPIO-1:0] fall;
  logic [NB_GPIO-1:0] stat_set;
  logic [NB_GPIO-1:0] w1c_bits;

  logic               access;
  logic               wr_en;
  logic               rd_en;
  logic [31:0]        addr_w;
  logic [31:0]        wmask_full;
  logic [31:0]        wdata_full;
  logic [NB_GPIO-1:0] wmask_n;
  logic [NB_GPIO-1:0] wdata_n;

  gpio_sync_edge #(
    .NB_GPIO     (NB_GPIO),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .mclk        (mclk),
    .h_reset     (h_reset),
    .pad_gpio_in (pad_gpio_in),
    .sync_in     (sync_in),
    .rise        (rise),
    .fall        (fall)
  );

  // An access is taken only on the first cycle reg_cs is seen high; busy_q
  // blocks re-triggering until the master drops reg_cs.
  assign access     = reg_cs & ~busy_q;
  assign wr_en      = access & reg_wr;
  assign rd_en      = access & ~reg_wr;
  assign addr_w     = 32'(reg_addr);
  assign wmask_full = be_to_mask(reg_be);
  assign wdata_full = reg_wdata & wmask_full;
  assign wmask_n    = wmask_full[NB_GPIO-1:0];
  assign wdata_n    = wdata_full[NB_GPIO-1:0];

  // Edge capture is independent of MASK; MASK only gates the interrupt.
  assign stat_set = (rise & pose_q) | (fall & nege_q);

  // Byte-enabled register writes and the sticky status update; a new edge
  // overrides a write-one-to-clear of the same bit.
  always_comb begin
    dir_d    = dir_q;
    out_d    = out_q;
    mask_d   = mask_q;
    pose_d   = pose_q;
    nege_d   = nege_q;
    mfunc_d  = mfunc_q;
    w1c_bits = '0;
    if (wr_en) begin
      case (addr_w)
        GPIO_DIR:   dir_d   = (dir_q   & ~wmask_n)    | wdata_n;
        GPIO_OUT:   out_d   = (out_q   & ~wmask_n)    | wdata_n;
        GPIO_STAT:  w1c_bits = wdata_n;
        GPIO_MASK:  mask_d  = (mask_q  & ~wmask_n)    | wdata_n;
        GPIO_POSE:  pose_d  = (pose_q  & ~wmask_n)    | wdata_n;
        GPIO_NEGE:  nege_d  = (nege_q  & ~wmask_n)    | wdata_n;
        GPIO_MFUNC: mfunc_d = (mfunc_q & ~wmask_full) | wdata_full;
        default:    ;
      endcase
    end
    stat_d = (stat_q & ~w1c_bits) | stat_set;
  end

  // Read mux; read data is only driven for the acknowledged read, 0 otherwise.
  always_comb begin
    rdata_d = '0;
    if (rd_en) begin
      case (addr_w)
        GPIO_DIR:   rdata_d = 32'(dir_q);
        GPIO_OUT:   rdata_d = 32'(out_q);
        GPIO_IN:    rdata_d = 32'(sync_in);
        GPIO_STAT:  rdata_d = 32'(stat_q);
        GPIO_MASK:  rdata_d = 32'(mask_q);
        GPIO_POSE:  rdata_d = 32'(pose_q);
        GPIO_NEGE:  rdata_d = 32'(nege_q);
        GPIO_MFUNC: rdata_d = mfunc_q;
        default:    rdata_d = '0;
      endcase
    end
  end

  // State registers, access handshake and the registered interrupt.
  always_ff @(posedge mclk or posedge h_reset) begin
    if (h_reset) begin
      dir_q   <= '0;
      out_q   <= '0;
      stat_q  <= '0;
      mask_q  <= '0;
      pose_q  <= '0;
      nege_q  <= '0;
      mfunc_q <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      intr_q  <= 1'b0;
    end else begin
      dir_q   <= dir_d;
      out_q   <= out_d;
      stat_q  <= stat_d;
      mask_q  <= mask_d;
      pose_q  <= pose_d;
      nege_q  <= nege_d;
      mfunc_q <= mfunc_d;
      rdata_q <= rdata_d;
      busy_q  <= reg_cs;
      ack_q   <= access;
      intr_q  <= |(stat_q & mask_q);
    end
  end

  assign reg_rdata          = rdata_q;
  assign reg_ack            = ack_q;
  assign cfg_gpio_dir_sel   = dir_q;
  assign pad_gpio_out       = out_q;
  assign cfg_multi_func_sel = mfunc_q;
  assign gpio_intr          = intr_q;

endmodule
